channel_dispatcher: RTL and testbench

- Initiator side of the per-output-channel completion protocol.
- On a layer start it walks output channels 0..CHANNELS. For each channel it issues one start pulse to the convolution engine, waits for that engine's done pulse, then emits one channel_done pulse.
- channel_done is the per-channel "signal" input of the downstream channel completion counter. Both blocks therefore use the same CHANNELS value and the same 4-bit channel index width.

---
 rtl/cnn_pkg.sv | 15 +
 rtl/wdog_timer.sv | 28 ++
 rtl/channel_dispatcher.sv | 138 +++++++++++++
 tb/tb_channel_dispatcher.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg: types and constants shared by the channel dispatcher and the
// downstream channel completion counter.
//   CH_W          - channel index width; both blocks must agree on it
//   disp_state_t  - dispatcher FSM states
package cnn_pkg;

  localparam int CH_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } disp_state_t;

endpackage

// File: rtl/wdog_timer.sv
// wdog_timer: cycle counter that flags expiry on the TC-th enabled cycle.
//   clk, rst_n  - clock, async active-low reset
//   clear       - zero the count (takes priority over enable)
//   enable      - count this cycle
//   expired     - combinational: this enabled cycle is the TC-th since clear
module wdog_timer #(
  parameter int TC = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TC + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= cnt + 1'b1;
  end

  assign expired = enable && (cnt == CW'(TC - 1));

endmodule

// File: rtl/channel_dispatcher.sv
// channel_dispatcher: initiator side of the per-output-channel completion
// protocol. On start it walks channels 0..CHANNELS; per channel it pulses
// engine_start, waits for engine_done, then pulses channel_done.
//   clk, rst_n    - clock, async active-low reset
//   start         - begin a layer (sampled only in IDLE)
//   engine_ready  - engine can accept a channel start
//   engine_done   - engine finished the current channel (pulse)
//   engine_start  - registered pulse launching channel_idx
//   channel_idx   - channel being issued / processed
//   channel_done  - registered pulse per finished channel
//   busy          - layer in progress
//   done          - sticky, set after last channel, cleared by next start
//   error         - sticky watchdog timeout
// Optional: define CHANNEL_DISPATCH_WDOG_EN to build the WAIT watchdog
// (timeout after WDOG_CYCLES). Without it, error is 0 and WAIT is unbounded.
module channel_dispatcher
  import cnn_pkg::*;
#(
  parameter int CHANNELS    = 7,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            engine_ready,
  input  logic            engine_done,
  output logic            engine_start,
  output logic [CH_W-1:0] channel_idx,
  output logic            channel_done,
  output logic            busy,
  output logic            done,
  output logic            error
);

  if (CHANNELS < 0 || CHANNELS > (1 << CH_W) - 1 || WDOG_CYCLES < 2) begin : g_bad_cfg
    $error("channel_dispatcher: illegal CHANNELS or WDOG_CYCLES");
  end

  localparam logic [CH_W-1:0] LAST = CH_W'(CHANNELS);

  disp_state_t     state_q, state_d;
  logic [CH_W-1:0] idx_d;
  logic            estart_d, cdone_d, done_d;
  logic            accept_done;

  // engine_done coinciding with our own engine_start belongs to nothing
  // we launched, so it is not accepted.
  assign accept_done = (state_q == WAIT) && engine_done && !engine_start;

`ifdef CHANNEL_DISPATCH_WDOG_EN
  logic err_q, err_d;
  logic wd_clear, wd_en, wd_expired;

  wdog_timer #(.TC(WDOG_CYCLES)) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (wd_clear),
    .enable  (wd_en),
    .expired (wd_expired)
  );

  assign wd_clear = (state_q == ISSUE) && engine_ready;
  assign wd_en    = (state_q == WAIT) && !accept_done;
  assign error    = err_q;
`else
  assign error = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = channel_idx;
    estart_d = 1'b0;
    cdone_d  = 1'b0;
    done_d   = done;
`ifdef CHANNEL_DISPATCH_WDOG_EN
    err_d    = err_q;
`endif
    unique case (state_q)
      IDLE: if (start) begin
        state_d = ISSUE;
        idx_d   = '0;
        done_d  = 1'b0;
`ifdef CHANNEL_DISPATCH_WDOG_EN
        err_d   = 1'b0;
`endif
      end
      ISSUE: if (engine_ready) begin
        estart_d = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        if (accept_done) begin
          cdone_d = 1'b1;
          if (channel_idx == LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ISSUE;
            idx_d   = channel_idx + 1'b1;
          end
        end
`ifdef CHANNEL_DISPATCH_WDOG_EN
        else if (wd_expired) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      channel_idx  <= '0;
      engine_start <= 1'b0;
      channel_done <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_q      <= state_d;
      channel_idx  <= idx_d;
      engine_start <= estart_d;
      channel_done <= cdone_d;
      done         <= done_d;
    end
  end

`ifdef CHANNEL_DISPATCH_WDOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
`endif

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_channel_dispatcher.sv
// tb_channel_dispatcher: directed bench for channel_dispatcher. Two instances
// share inputs: d7 (CHANNELS=7, WDOG_CYCLES=16) and d0 (CHANNELS=0).
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
module tb_channel_dispatcher;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, engine_ready = 1'b1, engine_done = 1'b0;

  logic       es7, cd7, busy7, done7, err7;
  logic [3:0] idx7;
  logic       es0, cd0, busy0, done0, err0;
  logic [3:0] idx0;

  int n_chk = 0, n_fail = 0;
  int es_cnt = 0, cd_cnt = 0, dbl = 0;
  logic es_prev = 1'b0;

  always #5 clk = ~clk;

  channel_dispatcher #(.CHANNELS(7), .WDOG_CYCLES(16)) d7 (
    .clk(clk), .rst_n(rst_n), .start(start), .engine_ready(engine_ready),
    .engine_done(engine_done), .engine_start(es7), .channel_idx(idx7),
    .channel_done(cd7), .busy(busy7), .done(done7), .error(err7));

  channel_dispatcher #(.CHANNELS(0), .WDOG_CYCLES(16)) d0 (
    .clk(clk), .rst_n(rst_n), .start(start), .engine_ready(engine_ready),
    .engine_done(engine_done), .engine_start(es0), .channel_idx(idx0),
    .channel_done(cd0), .busy(busy0), .done(done0), .error(err0));

  // Pulse counters for d7; cd_cnt also stands in for the completion counter.
  always @(negedge clk) begin
    if (es7) es_cnt++;
    if (cd7) cd_cnt++;
    if (es7 && es_prev) dbl++;
    es_prev = es7;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  // One CHANNELS=7 layer. bp_ch: hold engine_ready low 10 cycles in ISSUE
  // (with a spurious engine_done there). spur_ch: engine_done and start
  // alongside engine_start. abort_ch: reset during that channel's WAIT.
  task automatic layer7(input int bp_ch, input int spur_ch, input int abort_ch);
    es_cnt = 0; cd_cnt = 0; dbl = 0;
    start = 1'b1; tick; start = 1'b0;
    chk("acc_busy", 32'(busy7), 1);
    chk("acc_idx", 32'(idx7), 0);
    chk("acc_done", 32'(done7), 0);
    for (int ch = 0; ch <= 7; ch++) begin
      if (ch == bp_ch) begin
        engine_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
          engine_done = (k == 0);
          tick;
        end
        engine_done = 1'b0;
        chk("bp_no_start", 32'(es7), 0);
        chk("bp_no_cdone", 32'(cd7), 0);
        chk("bp_idx", 32'(idx7), ch);
        engine_ready = 1'b1;
      end
      tick;
      chk($sformatf("start_ch%0d", ch), 32'(es7), 1);
      chk($sformatf("idx_ch%0d", ch), 32'(idx7), ch);
      if (ch == abort_ch) begin
        tick;
        rst_n = 1'b0;
        #1;
        chk("rst_outs", 32'({es7, cd7, busy7, done7, err7, idx7}), 0);
        tick;
        rst_n = 1'b1;
        tick;
        return;
      end
      engine_done = (ch == spur_ch);
      start       = (ch == spur_ch);
      tick;
      engine_done = 1'b0;
      start       = 1'b0;
      if (ch == spur_ch) begin
        chk("spur_cdone", 32'(cd7), 0);
        chk("spur_idx", 32'(idx7), ch);
        chk("spur_start", 32'(es7), 0);
      end
      repeat (4) tick;
      engine_done = 1'b1;
      tick;
      engine_done = 1'b0;
      chk($sformatf("cdone_ch%0d", ch), 32'(cd7), 1);
    end
    chk("end_done", 32'(done7), 1);
    chk("end_busy", 32'(busy7), 0);
    chk("end_idx", 32'(idx7), 7);
    tick;
    chk("n_start", es_cnt, 8);
    chk("n_cdone", cd_cnt, 8);
    chk("no_double", dbl, 0);
    chk("counter_complete", 32'(cd_cnt == 8), 1);
    chk("done_sticky", 32'(done7), 1);
  endtask

  initial begin
    do_reset;
    rst_n = 1'b0; #1;
    chk("rst_state", 32'({es7, cd7, busy7, done7, err7, idx7}), 0);
    rst_n = 1'b1;
    tick;

    // spurious engine_done in IDLE
    engine_done = 1'b1; tick; engine_done = 1'b0;
    chk("idle_spur_cdone", 32'(cd7), 0);
    chk("idle_spur_busy", 32'(busy7), 0);

    layer7(-1, -1, -1);   // nominal
    layer7(3, 1, -1);     // backpressure + spurious
    layer7(-1, -1, 4);    // reset mid-layer
    layer7(-1, -1, -1);   // fresh layer restarts at channel 0

    // CHANNELS=0 layer, then start in the same cycle done is high
    do_reset;
    start = 1'b1; tick; start = 1'b0;
    tick;
    chk("c0_start", 32'(es0), 1);
    chk("c0_idx", 32'(idx0), 0);
    repeat (4) tick;
    engine_done = 1'b1; tick; engine_done = 1'b0;
    chk("c0_cdone", 32'(cd0), 1);
    chk("c0_done", 32'(done0), 1);
    chk("c0_busy", 32'(busy0), 0);
    start = 1'b1; tick; start = 1'b0;
    chk("c0_restart_done", 32'(done0), 0);
    chk("c0_restart_busy", 32'(busy0), 1);
    chk("c0_restart_idx", 32'(idx0), 0);

    // Engine never answers channel 0 of d7
    do_reset;
    start = 1'b1; tick; start = 1'b0;
    tick;
    chk("wd_start", 32'(es7), 1);
`ifdef CHANNEL_DISPATCH_WDOG_EN
    repeat (15) tick;
    chk("wd_pre_err", 32'(err7), 0);
    chk("wd_pre_busy", 32'(busy7), 1);
    tick;
    chk("wd_err", 32'(err7), 1);
    chk("wd_busy", 32'(busy7), 0);
    chk("wd_done", 32'(done7), 0);
    chk("wd_cdone", 32'(cd7), 0);
    start = 1'b1; tick; start = 1'b0;
    chk("wd_err_clr", 32'(err7), 0);
    chk("wd_restart_busy", 32'(busy7), 1);
`else
    repeat (40) tick;
    chk("nowd_err", 32'(err7), 0);
    chk("nowd_busy", 32'(busy7), 1);
    chk("nowd_idx", 32'(idx7), 0);
    chk("nowd_cdone", 32'(cd7), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
